apb_master: RTL and testbench
=============================

// Module: apb_master
// PURPOSE
//  APB initiator: converts a simple valid/ready command stream into APB3 transfers and returns
//  one valid/ready response per command. Drives timer_top-class APB slaves (PREADY/PSLVERR aware).
//  Sits between a CPU-side/test sequencer and the peripheral APB bus; one outstanding transfer.
// PARAMETERS
//  ADR_W    32  address width (CMD_ADDR, PADDR)
//  DAT_W    32  data width (CMD_WDATA, PWDATA, PRDATA, RSP_RDATA)
//  TIMEOUT  16  max ACCESS cycles waiting for PREADY before abort; 0 = no timeout
// PORTS
//  PCLK       in   1      clock; all logic on rising edge
//  PRESET     in   1      reset, synchronous, active-high
//  CMD_VALID  in   1      command present
//  CMD_READY  out  1      command accepted when CMD_VALID & CMD_READY
//  CMD_WRITE  in   1      1 = write, 0 = read
//  CMD_ADDR   in   ADR_W  transfer address
//  CMD_WDATA  in   DAT_W  write data
//  RSP_VALID  out  1      response present
//  RSP_READY  in   1      response consumed when RSP_VALID & RSP_READY
//  RSP_RDATA  out  DAT_W  read data (0 for writes and aborted transfers)
//  RSP_ERR    out  1      PSLVERR seen, or timeout
//  RSP_TOUT   out  1      transfer aborted by timeout
//  PADDR      out  ADR_W  APB address
//  PSEL       out  1      APB select
//  PENABLE    out  1      APB enable
//  PWRITE     out  1      APB direction
//  PWDATA     out  DAT_W  APB write data
//  PREADY     in   1      slave ready
//  PRDATA     in   DAT_W  slave read data
//  PSLVERR    in   1      slave error
// BEHAVIOUR
//  - Reset (PRESET=1 at edge): state IDLE; every output 0 except CMD_READY=1; timeout cnt 0.
//    Mid-transfer reset: PSEL/PENABLE/RSP_VALID low after that edge; pending response dropped.
//  - All APB and RSP outputs are registered. CMD_READY = (state==IDLE).
//  - FSM: IDLE -> SETUP -> ACCESS -> RESP -> IDLE.
//    IDLE  : on CMD_VALID: latch WRITE/ADDR/WDATA into PWRITE/PADDR/PWDATA (PWDATA=0 for
//            reads); go SETUP. Otherwise stay; PADDR/PWRITE/PWDATA keep last value.
//    SETUP : PSEL=1, PENABLE=0; unconditionally -> ACCESS next edge.
//    ACCESS: PSEL=1, PENABLE=1; PADDR/PWRITE/PWDATA stable. On edge with PREADY=1: capture
//            RSP_RDATA = PWRITE ? 0 : PRDATA, RSP_ERR = PSLVERR, RSP_TOUT=0; PSEL/PENABLE -> 0;
//            -> RESP. PREADY=0: count++.
//    Timeout: TIMEOUT>0 and PREADY=0 on the TIMEOUT-th ACCESS cycle -> PSEL/PENABLE -> 0,
//            RSP_RDATA=0, RSP_ERR=1, RSP_TOUT=1, -> RESP. PREADY=1 on that cycle wins (normal).
//    RESP  : RSP_VALID=1, RSP_* held stable until RSP_READY=1; then RSP_VALID -> 0, -> IDLE.
//  - Counter: $clog2(TIMEOUT+1) bits, cleared on entry to ACCESS; never wraps.
//  - PREADY, PRDATA, PSLVERR ignored outside ACCESS. CMD_* ignored outside IDLE.
//  - Latency: accept at edge N -> SETUP cycle N+1 -> ACCESS N+2 -> RSP_VALID from N+3 with
//    zero wait states. Back-to-back with RSP_READY=1: one transfer every 4 cycles.
// TESTING
//  1 Write 0x1234_5678 to 0x004, PREADY=1: SETUP 1 cyc, ACCESS 1 cyc, PWRITE=1; RSP_ERR=0, RDATA=0.
//  2 Read 0x008, PREADY low 3 cyc, PRDATA=0xCAFE_F00D: ACCESS 4 cyc, RSP_RDATA=0xCAFEF00D.
//  3 Read with PSLVERR=1 at PREADY: RSP_ERR=1, RSP_TOUT=0; next command accepted after RSP_READY.
//  4 TIMEOUT=16, PREADY stuck 0: 16 ACCESS cycles, then PSEL=0, RSP_ERR=1, RSP_TOUT=1, RDATA=0.
//  5 RSP_READY=0 for 5 cycles: RSP_* stable, CMD_READY=0, no new PSEL until response taken.
//  6 PRESET pulse during ACCESS: PSEL/PENABLE=0 next edge, no RSP_VALID, CMD_READY=1.

Source files
------------

// File: rtl/apb_master.sv
// apb_master: valid/ready command stream to APB3 initiator with one outstanding transfer and access timeout
module apb_master #(
    parameter int ADR_W   = 32,
    parameter int DAT_W   = 32,
    parameter int TIMEOUT = 16
) (
    input  logic             PCLK,
    input  logic             PRESET,
    input  logic             CMD_VALID,
    output logic             CMD_READY,
    input  logic             CMD_WRITE,
    input  logic [ADR_W-1:0] CMD_ADDR,
    input  logic [DAT_W-1:0] CMD_WDATA,
    output logic             RSP_VALID,
    input  logic             RSP_READY,
    output logic [DAT_W-1:0] RSP_RDATA,
    output logic             RSP_ERR,
    output logic             RSP_TOUT,
    output logic [ADR_W-1:0] PADDR,
    output logic             PSEL,
    output logic             PENABLE,
    output logic             PWRITE,
    output logic [DAT_W-1:0] PWDATA,
    input  logic             PREADY,
    input  logic [DAT_W-1:0] PRDATA,
    input  logic             PSLVERR
);
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;
    localparam int CW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);
    state_t state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic psel_n, penable_n, pwrite_n, rsp_valid_n, rsp_err_n, rsp_tout_n, tout_hit;
    logic [ADR_W-1:0] paddr_n;
    logic [DAT_W-1:0] pwdata_n, rsp_rdata_n;
    assign CMD_READY = state == IDLE;
    assign tout_hit = (TIMEOUT != 0) && cnt == CNT_LAST;
    // next state and next register values; everything holds unless the current phase changes it
    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        psel_n      = PSEL;
        penable_n   = PENABLE;
        paddr_n     = PADDR;
        pwrite_n    = PWRITE;
        pwdata_n    = PWDATA;
        rsp_valid_n = RSP_VALID;
        rsp_rdata_n = RSP_RDATA;
        rsp_err_n   = RSP_ERR;
        rsp_tout_n  = RSP_TOUT;
        case (state)
            IDLE: if (CMD_VALID) begin
                state_n  = SETUP;
                psel_n   = 1'b1;
                paddr_n  = CMD_ADDR;
                pwrite_n = CMD_WRITE;
                pwdata_n = CMD_WRITE ? CMD_WDATA : '0;
            end
            SETUP: begin
                state_n   = ACCESS;
                penable_n = 1'b1;
                cnt_n     = '0;
            end
            ACCESS: if (PREADY || tout_hit) begin
                state_n     = RESP;
                psel_n      = 1'b0;
                penable_n   = 1'b0;
                rsp_valid_n = 1'b1;
                rsp_rdata_n = (PREADY && !PWRITE) ? PRDATA : '0;
                rsp_err_n   = PREADY ? PSLVERR : 1'b1;
                rsp_tout_n  = !PREADY;
            end else begin
                cnt_n = &cnt ? cnt : cnt + CW'(1);
            end
            RESP: if (RSP_READY) begin
                state_n     = IDLE;
                rsp_valid_n = 1'b0;
            end
            default: state_n = IDLE;
        endcase
    end
    // state and all APB/response outputs are registered
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state     <= IDLE;
            cnt       <= '0;
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            PADDR     <= '0;
            PWRITE    <= 1'b0;
            PWDATA    <= '0;
            RSP_VALID <= 1'b0;
            RSP_RDATA <= '0;
            RSP_ERR   <= 1'b0;
            RSP_TOUT  <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            PSEL      <= psel_n;
            PENABLE   <= penable_n;
            PADDR     <= paddr_n;
            PWRITE    <= pwrite_n;
            PWDATA    <= pwdata_n;
            RSP_VALID <= rsp_valid_n;
            RSP_RDATA <= rsp_rdata_n;
            RSP_ERR   <= rsp_err_n;
            RSP_TOUT  <= rsp_tout_n;
        end
    end
endmodule

// File: tb/tb_apb_master.sv
// tb_apb_master: table vectors, randomized transfers against a transaction-level model, reset corners
module tb_apb_master;
    localparam int TIMEOUT = 16;
    logic        PCLK = 1'b0, PRESET = 1'b1;
    logic        CMD_VALID = 1'b0, CMD_WRITE = 1'b0, CMD_READY;
    logic [31:0] CMD_ADDR = '0, CMD_WDATA = '0;
    logic        RSP_VALID, RSP_READY = 1'b0, RSP_ERR, RSP_TOUT;
    logic [31:0] RSP_RDATA, PADDR, PWDATA;
    logic        PSEL, PENABLE, PWRITE;
    logic        PREADY = 1'b0, PSLVERR = 1'b0;
    logic [31:0] PRDATA = '0;
    int checks = 0, errors = 0;

    apb_master #(.ADR_W(32), .DAT_W(32), .TIMEOUT(TIMEOUT)) dut (
        .PCLK(PCLK), .PRESET(PRESET), .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
        .CMD_WRITE(CMD_WRITE), .CMD_ADDR(CMD_ADDR), .CMD_WDATA(CMD_WDATA),
        .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_RDATA(RSP_RDATA),
        .RSP_ERR(RSP_ERR), .RSP_TOUT(RSP_TOUT), .PADDR(PADDR), .PSEL(PSEL),
        .PENABLE(PENABLE), .PWRITE(PWRITE), .PWDATA(PWDATA), .PREADY(PREADY),
        .PRDATA(PRDATA), .PSLVERR(PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    typedef struct {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          waits;
        logic [31:0] rdata;
        logic        slverr;
        int          delay;
        int          e_acc;
        logic [31:0] e_rdata;
        logic        e_err;
        logic        e_tout;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // transfer outcome from the protocol rules: access lasts until PREADY or the timeout budget runs out
    function automatic vec_t model(input vec_t v);
        vec_t r = v;
        logic tout = (TIMEOUT > 0) && (v.waits >= TIMEOUT);
        r.e_acc   = tout ? TIMEOUT : v.waits + 1;
        r.e_tout  = tout;
        r.e_err   = tout || v.slverr;
        r.e_rdata = (tout || v.write) ? 32'h0 : v.rdata;
        return r;
    endfunction

    task automatic run(input vec_t v, input string tag);
        int acc = 0;
        logic rdy;
        logic [31:0] exp_wd = v.write ? v.wdata : 32'h0;
        chk({tag, ".idle_ready"}, 64'(CMD_READY), 64'd1);
        CMD_VALID = 1'b1; CMD_WRITE = v.write; CMD_ADDR = v.addr; CMD_WDATA = v.wdata;
        PREADY = 1'($urandom); PSLVERR = 1'($urandom); PRDATA = $urandom;
        @(negedge PCLK);
        chk({tag, ".setup_psel"}, 64'(PSEL), 64'd1);
        chk({tag, ".setup_penable"}, 64'(PENABLE), 64'd0);
        chk({tag, ".paddr"}, 64'(PADDR), 64'(v.addr));
        chk({tag, ".pwrite"}, 64'(PWRITE), 64'(v.write));
        chk({tag, ".pwdata"}, 64'(PWDATA), 64'(exp_wd));
        chk({tag, ".busy_ready"}, 64'(CMD_READY), 64'd0);
        CMD_VALID = 1'($urandom); CMD_WRITE = 1'($urandom); CMD_ADDR = $urandom; CMD_WDATA = $urandom;
        for (int k = 0; k < 40; k++) begin
            @(negedge PCLK);
            if (!(PSEL && PENABLE)) break;
            acc++;
            chk({tag, ".acc_paddr"}, 64'({PADDR, PWDATA}), 64'({v.addr, exp_wd}));
            rdy = acc > v.waits;
            PREADY = rdy;
            PRDATA = rdy ? v.rdata : $urandom;
            PSLVERR = rdy ? v.slverr : 1'($urandom);
        end
        PREADY = 1'($urandom); PSLVERR = 1'($urandom); PRDATA = $urandom;
        chk({tag, ".access_cycles"}, 64'(acc), 64'(v.e_acc));
        chk({tag, ".resp_psel_pen"}, 64'({PSEL, PENABLE}), 64'd0);
        chk({tag, ".rsp_valid"}, 64'(RSP_VALID), 64'd1);
        chk({tag, ".rsp_rdata"}, 64'(RSP_RDATA), 64'(v.e_rdata));
        chk({tag, ".rsp_err_tout"}, 64'({RSP_ERR, RSP_TOUT}), 64'({v.e_err, v.e_tout}));
        for (int d = 0; d < v.delay; d++) begin
            @(negedge PCLK);
            chk({tag, ".hold_rsp"}, 64'({RSP_VALID, RSP_ERR, RSP_TOUT, RSP_RDATA}),
                64'({1'b1, v.e_err, v.e_tout, v.e_rdata}));
            chk({tag, ".hold_bus"}, 64'({CMD_READY, PSEL}), 64'd0);
        end
        RSP_READY = 1'b1;
        @(negedge PCLK);
        RSP_READY = 1'b0; CMD_VALID = 1'b0;
        chk({tag, ".rsp_taken"}, 64'({RSP_VALID, CMD_READY, PSEL}), 64'b010);
    endtask

    vec_t tbl[7];

    initial begin
        tbl[0] = '{1'b1, 32'h004, 32'h1234_5678, 0,   32'h0,         1'b0, 0, 1,  32'h0,         1'b0, 1'b0};
        tbl[1] = '{1'b0, 32'h008, 32'h0,         3,   32'hCAFE_F00D, 1'b0, 1, 4,  32'hCAFE_F00D, 1'b0, 1'b0};
        tbl[2] = '{1'b0, 32'h010, 32'h5555_AAAA, 1,   32'h0000_DEAD, 1'b1, 0, 2,  32'h0000_DEAD, 1'b1, 1'b0};
        tbl[3] = '{1'b0, 32'h020, 32'h0,         100, 32'h1111_2222, 1'b0, 0, 16, 32'h0,         1'b1, 1'b1};
        tbl[4] = '{1'b1, 32'h030, 32'h0000_AA55, 2,   32'hFFFF_FFFF, 1'b0, 5, 3,  32'h0,         1'b0, 1'b0};
        tbl[5] = '{1'b0, 32'h034, 32'h0,         15,  32'h0000_0077, 1'b0, 2, 16, 32'h0000_0077, 1'b0, 1'b0};
        tbl[6] = '{1'b1, 32'h038, 32'hBEEF_0001, 16,  32'h0,         1'b1, 0, 16, 32'h0,         1'b1, 1'b1};
        CMD_VALID = 1'b1; CMD_WRITE = 1'b1; CMD_ADDR = 32'hFFFF_FFFF; CMD_WDATA = 32'hFFFF_FFFF;
        PREADY = 1'b1; PRDATA = 32'hFFFF_FFFF; PSLVERR = 1'b1; RSP_READY = 1'b1;
        repeat (2) @(negedge PCLK);
        chk("reset.cmd_ready", 64'(CMD_READY), 64'd1);
        chk("reset.apb_ctl", 64'({PSEL, PENABLE, PWRITE}), 64'd0);
        chk("reset.paddr_pwdata", 64'({PADDR, PWDATA}), 64'd0);
        chk("reset.rsp", 64'({RSP_VALID, RSP_ERR, RSP_TOUT, RSP_RDATA}), 64'd0);
        PRESET = 1'b0; CMD_VALID = 1'b0; PREADY = 1'b0; PSLVERR = 1'b0; RSP_READY = 1'b0;
        @(negedge PCLK);
        chk("idle.no_psel", 64'({PSEL, RSP_VALID, CMD_READY}), 64'b001);
        for (int i = 0; i < 7; i++) run(tbl[i], $sformatf("vec%0d", i));
        CMD_VALID = 1'b1; CMD_WRITE = 1'b0; CMD_ADDR = 32'h40;
        @(negedge PCLK);
        CMD_VALID = 1'b0; PREADY = 1'b0;
        @(negedge PCLK);
        chk("midrst.in_access", 64'({PSEL, PENABLE}), 64'b11);
        PRESET = 1'b1; PREADY = 1'b1; PRDATA = 32'h1234;
        @(negedge PCLK);
        chk("midrst.after_edge", 64'({PSEL, PENABLE, RSP_VALID, CMD_READY}), 64'b0001);
        PRESET = 1'b0;
        @(negedge PCLK);
        chk("midrst.no_rsp", 64'({PSEL, PENABLE, RSP_VALID, CMD_READY}), 64'b0001);
        PREADY = 1'b0;
        for (int i = 0; i < 40; i++) begin
            vec_t v;
            v.write  = 1'($urandom);
            v.addr   = $urandom;
            v.wdata  = $urandom;
            v.waits  = ($urandom_range(0, 5) == 0) ? int'($urandom_range(13, 20)) : int'($urandom_range(0, 4));
            v.rdata  = $urandom;
            v.slverr = ($urandom_range(0, 3) == 0);
            v.delay  = $urandom_range(0, 3);
            run(model(v), $sformatf("rnd%0d", i));
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
